// File: rtl/vdp2_write_fifo_gen.sv
// rtl/vdp2_write_fifo_gen.sv - parametrised show-ahead write FIFO for VDP2 CPU/VRAM write buffering
// Optional feature macro: VDP2_WFIFO_ERRFLAG_EN enables the sticky OVF/UDF error flags;
// without it OVF and UDF are tied low and their registers are omitted.
module vdp2_write_fifo_gen #(
  parameter int DATA_W     = 34,
  parameter int DEPTH_LOG2 = 3,
  parameter int AFULL_LVL  = (1 << DEPTH_LOG2) - 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic [DATA_W-1:0]     DATA,
  input  logic                  WRREQ,
  input  logic                  RDREQ,
  output logic [DATA_W-1:0]     Q,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  LAST,
  output logic                  AFULL,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVF,
  output logic                  UDF
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LVL);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [LW-1:0]         level;
  logic                  wr_ok;
  logic                  rd_ok;

  // Accept decode: a write into a full FIFO is fine when the head leaves on the same edge;
  // a read from an empty FIFO is always ignored, even alongside a write.
  always_comb begin
    wr_ok = WRREQ && (!FULL || RDREQ);
    rd_ok = RDREQ && !EMPTY;
  end

  // Storage write; no reset so the array stays plain distributed RAM
  always_ff @(posedge CLK) begin
    if (wr_ok && !FLUSH && !RST) begin
      mem[waddr] <= DATA;
    end
  end

  // Pointers and level counter; FLUSH overrides any request on the same edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      waddr <= '0;
      raddr <= '0;
      level <= '0;
    end else if (FLUSH) begin
      waddr <= '0;
      raddr <= '0;
      level <= '0;
    end else begin
      if (wr_ok) begin
        waddr <= waddr + 1'b1;
      end
      if (rd_ok) begin
        raddr <= raddr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        level <= level + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        level <= level - 1'b1;
      end
    end
  end

  // Show-ahead head and status flags, all decoded from the registered level
  always_comb begin
    Q     = mem[raddr];
    LEVEL = level;
    EMPTY = (level == '0);
    FULL  = (level == LVL_FULL);
    LAST  = (level == LVL_ONE);
    AFULL = (level >= LVL_AFULL);
  end

`ifdef VDP2_WFIFO_ERRFLAG_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags, cleared only by reset or flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (FLUSH) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WRREQ && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (RDREQ && !rd_ok) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`else
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

endmodule
